hazard_ctrl: RTL

- Pipeline hazard controller for the 5-stage ARM datapath.
- Tracks the destination register of the instructions in EX and MEM and compares them with the source registers of the instruction in ID, using 5-bit register-index equality.
- Produces registered forwarding selects for the EX-stage ALU operands, a load-use stall, and bubble insertion on flush.
- Keeps saturating stall and flush event counters for debug.

---
 rtl/hazard_pkg.sv | 31 +++
 rtl/reg_match.sv | 19 +
 rtl/hazard_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
`default_nettype none

package hazard_pkg;

  localparam logic [4:0] ZERO_REG = 5'd31;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr;
    logic       load;
  } stage_track_t;

  // Newest producer wins; a load sitting in EX cannot forward yet (stall covers it).
  function automatic fwd_sel_t pick_fwd(input logic hit_ex, input logic ex_is_load,
                                        input logic hit_mem);
    if (hit_ex && !ex_is_load) return FWD_EXMEM;
    if (hit_mem)               return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_match.sv
// Source/destination register-index comparator with zero-register exclusion.
`default_nettype none

module reg_match #(
  parameter logic [4:0] ZERO_REG = hazard_pkg::ZERO_REG
) (
  input  logic [4:0] src,
  input  logic [4:0] dst,
  input  logic       use_src,
  input  logic       dst_valid,
  input  logic       dst_wr,
  output logic       match
);

  assign match = use_src & dst_valid & dst_wr & (src == dst) & (src != ZERO_REG);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// Hazard controller: tracks EX/MEM destinations, drives registered forwarding
// selects, the load-use stall, bubble insertion and saturating debug counters.
`default_nettype none

module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter logic [4:0]  ZERO_REG = hazard_pkg::ZERO_REG
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic [4:0]       id_rd,
  input  logic             id_wr_en,
  input  logic             id_is_load,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  stage_track_t ex_q;
  stage_track_t ex_d;
  logic         mem_valid_q;
  logic [4:0]   mem_rd_q;
  logic         mem_wr_q;

  logic     rn_ex;
  logic     rm_ex;
  logic     rn_mem;
  logic     rm_mem;
  logic     advance;
  fwd_sel_t fwd_a_d;
  fwd_sel_t fwd_b_d;
  fwd_sel_t fwd_a_q;
  fwd_sel_t fwd_b_q;

  reg_match #(.ZERO_REG(ZERO_REG)) u_rn_ex (
    .src       (id_rn),
    .dst       (ex_q.rd),
    .use_src   (id_use_rn),
    .dst_valid (ex_q.valid),
    .dst_wr    (ex_q.wr),
    .match     (rn_ex)
  );

  reg_match #(.ZERO_REG(ZERO_REG)) u_rm_ex (
    .src       (id_rm),
    .dst       (ex_q.rd),
    .use_src   (id_use_rm),
    .dst_valid (ex_q.valid),
    .dst_wr    (ex_q.wr),
    .match     (rm_ex)
  );

  reg_match #(.ZERO_REG(ZERO_REG)) u_rn_mem (
    .src       (id_rn),
    .dst       (mem_rd_q),
    .use_src   (id_use_rn),
    .dst_valid (mem_valid_q),
    .dst_wr    (mem_wr_q),
    .match     (rn_mem)
  );

  reg_match #(.ZERO_REG(ZERO_REG)) u_rm_mem (
    .src       (id_rm),
    .dst       (mem_rd_q),
    .use_src   (id_use_rm),
    .dst_valid (mem_valid_q),
    .dst_wr    (mem_wr_q),
    .match     (rm_mem)
  );

  // Flush squashes the consumer, so a load-use hazard under flush needs no stall.
  always_comb begin
    stall   = id_valid & ~flush & ex_q.load & (rn_ex | rm_ex);
    advance = id_valid & ~stall & ~flush;
  end

  // A non-advancing slot becomes a bubble: valid, wr and load all cleared.
  always_comb begin
    ex_d    = '0;
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (advance) begin
      ex_d.valid = 1'b1;
      ex_d.rd    = id_rd;
      ex_d.wr    = id_wr_en;
      ex_d.load  = id_is_load;
      fwd_a_d    = pick_fwd(rn_ex, ex_q.load, rn_mem);
      fwd_b_d    = pick_fwd(rm_ex, ex_q.load, rm_mem);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q        <= '0;
      mem_valid_q <= 1'b0;
      mem_rd_q    <= '0;
      mem_wr_q    <= 1'b0;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
    end else begin
      ex_q        <= ex_d;
      mem_valid_q <= ex_q.valid;
      mem_rd_q    <= ex_q.rd;
      mem_wr_q    <= ex_q.wr;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;

  // Clear has priority over counting; counters stick at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire
